// File: rtl/ascon_perm_engine.sv
// rtl/ascon_perm_engine.sv - self-sequencing Ascon p12/p8 permutation with begin/end XOR
module ascon_perm_engine #(
  parameter int UNROLL   = 1,
  parameter int ROUNDS_A = 12,
  parameter int ROUNDS_B = 8
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic         mode_i,
  input  logic [319:0] state_i,
  input  logic         xor_b_en_i,
  input  logic [127:0] data_xor_b_i,
  input  logic [1:0]   xor_e_mode_i,
  input  logic [127:0] data_xor_e_i,
  output logic [319:0] state_o,
  output logic         busy_o,
  output logic         done_o
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  // Round indices run up to 11; reaching 12 means the last group was just applied.
  localparam logic [3:0] R_END   = 4'd12;
  localparam logic [3:0] R_BEG_A = 4'(12 - ROUNDS_A);
  localparam logic [3:0] R_BEG_B = 4'(12 - ROUNDS_B);
  localparam logic [3:0] R_STEP  = 4'(UNROLL);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4)) begin : g_bad_unroll
    $error("ascon_perm_engine: UNROLL must be 1, 2 or 4");
  end
  if ((ROUNDS_A % UNROLL) != 0 || (ROUNDS_B % UNROLL) != 0 ||
      ROUNDS_A < 1 || ROUNDS_A > 12 || ROUNDS_B < 1 || ROUNDS_B > 12) begin : g_bad_rounds
    $error("ascon_perm_engine: round counts must be 1..12 and divisible by UNROLL");
  end

  function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // One Ascon round: constant addition, bit-sliced S-box, linear diffusion.
  function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] r);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    logic [7:0]  rc;
    x0 = s[319:256];
    x1 = s[255:192];
    x2 = s[191:128];
    x3 = s[127:64];
    x4 = s[63:0];
    rc = {4'd15 - r, r};
    x2 = x2 ^ {56'd0, rc};
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    x0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
    x1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
    x2 = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
    x3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
    x4 = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

  logic [0:0]   fsm;
  logic [3:0]   rnd_cnt;
  logic [319:0] st_q;
  logic [1:0]   xe_mode_q;
  logic [127:0] xe_data_q;
  logic         done_q;

  logic         launch;
  logic         last_grp;
  logic [3:0]   r_base;
  logic [3:0]   r_next;
  logic [319:0] s_in;
  logic [319:0] s_rnd;
  logic [319:0] s_end;
  logic [1:0]   e_mode;
  logic [127:0] e_data;

  // Next-state datapath: pick fresh input on launch, else the register, then UNROLL rounds and end-XOR.
  always_comb begin
    launch   = (fsm == S_IDLE) && start_i;
    r_base   = launch ? (mode_i ? R_BEG_B : R_BEG_A) : rnd_cnt;
    s_in     = launch ? (state_i ^ (xor_b_en_i ? {data_xor_b_i, 192'd0} : 320'd0)) : st_q;
    s_rnd    = s_in;
    for (int i = 0; i < UNROLL; i++) begin
      s_rnd = ascon_round(s_rnd, r_base + 4'(i));
    end
    r_next   = r_base + R_STEP;
    last_grp = (r_next == R_END);
    e_mode   = launch ? xor_e_mode_i : xe_mode_q;
    e_data   = launch ? data_xor_e_i : xe_data_q;
    s_end    = s_rnd;
    if (e_mode[0]) begin
      s_end[127:0] = s_end[127:0] ^ e_data;
    end
    if (e_mode[1]) begin
      s_end[0] = ~s_end[0];
    end
  end

  // Sequencer: advance one round group per clock, finish with end-XOR and a done pulse.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      fsm       <= S_IDLE;
      rnd_cnt   <= 4'd0;
      st_q      <= 320'd0;
      xe_mode_q <= 2'b00;
      xe_data_q <= 128'd0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (launch || fsm == S_RUN) begin
        rnd_cnt <= r_next;
        if (last_grp) begin
          st_q   <= s_end;
          fsm    <= S_IDLE;
          done_q <= 1'b1;
        end else begin
          st_q <= s_rnd;
          fsm  <= S_RUN;
        end
      end
      if (launch) begin
        xe_mode_q <= xor_e_mode_i;
        xe_data_q <= data_xor_e_i;
      end
    end
  end

  assign state_o = st_q;
  assign busy_o  = (fsm == S_RUN);
  assign done_o  = done_q;

endmodule

// File: tb/tb_ascon_perm_engine.sv
// tb/tb_ascon_perm_engine.sv - scoreboard bench for ascon_perm_engine at UNROLL 1, 2 and 4
module tb_ascon_perm_engine;

  localparam int UN [3] = '{1, 2, 4};

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  localparam logic [127:0] KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [319:0] INIT = {64'h00001000808c0001, KEY, KEY};

  typedef struct {
    logic [319:0] st;
    int           due;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic         mode;
  logic [319:0] state_in;
  logic         xb_en;
  logic [127:0] xb_data;
  logic [1:0]   xe_mode;
  logic [127:0] xe_data;
  logic [319:0] st_w   [3];
  logic         busy_w [3];
  logic         done_w [3];

  exp_t         sb [3][$];
  logic [319:0] last_st [3];
  int           cyc;
  int           n_pass;
  int           n_fail;
  int           n_total;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ascon_perm_engine #(.UNROLL(UN[g]), .ROUNDS_A(12), .ROUNDS_B(8)) u_dut (
      .clock_i      (clk),
      .reset_i      (rst),
      .start_i      (start),
      .mode_i       (mode),
      .state_i      (state_in),
      .xor_b_en_i   (xb_en),
      .data_xor_b_i (xb_data),
      .xor_e_mode_i (xe_mode),
      .data_xor_e_i (xe_data),
      .state_o      (st_w[g]),
      .busy_o       (busy_w[g]),
      .done_o       (done_w[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] rr(input logic [63:0] x, input int n);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[i] = x[(i + n) % 64];
    return y;
  endfunction

  // Reference permutation using the S-box table, plus begin/end XOR.
  function automatic logic [319:0] model(input logic m, input logic [319:0] s,
                                         input logic xben, input logic [127:0] xb,
                                         input logic [1:0] xem, input logic [127:0] xe);
    logic [63:0]  x [5];
    logic [63:0]  y [5];
    logic [4:0]   idx;
    logic [4:0]   o;
    logic [319:0] t;
    int           nr;
    nr = m ? 8 : 12;
    t  = s;
    if (xben) t[319:192] = t[319:192] ^ xb;
    for (int i = 0; i < 5; i++) x[i] = t[319 - 64*i -: 64];
    for (int r = 12 - nr; r < 12; r++) begin
      x[2][7:0] = x[2][7:0] ^ 8'(((15 - r) << 4) | r);
      for (int j = 0; j < 64; j++) begin
        idx = {x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]};
        o   = SBOX[idx];
        for (int i = 0; i < 5; i++) y[i][j] = o[4 - i];
      end
      x[0] = y[0] ^ rr(y[0], 19) ^ rr(y[0], 28);
      x[1] = y[1] ^ rr(y[1], 61) ^ rr(y[1], 39);
      x[2] = y[2] ^ rr(y[2], 1)  ^ rr(y[2], 6);
      x[3] = y[3] ^ rr(y[3], 10) ^ rr(y[3], 17);
      x[4] = y[4] ^ rr(y[4], 7)  ^ rr(y[4], 41);
    end
    t = {x[0], x[1], x[2], x[3], x[4]};
    if (xem[0]) t[127:0] = t[127:0] ^ xe;
    if (xem[1]) t[0] = ~t[0];
    return t;
  endfunction

  function automatic logic [319:0] rnd320();
    logic [319:0] v;
    for (int i = 0; i < 10; i++) v[32*i +: 32] = $urandom();
    return v;
  endfunction

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and compare every DUT against the scoreboard.
  task automatic tick();
    logic e_done;
    logic e_busy;
    @(negedge clk);
    cyc++;
    for (int k = 0; k < 3; k++) begin
      e_done = (sb[k].size() > 0) && (sb[k][0].due == cyc);
      e_busy = (sb[k].size() > 0) && !e_done;
      chk($sformatf("done_u%0d_c%0d", UN[k], cyc), {319'd0, done_w[k]}, {319'd0, e_done});
      chk($sformatf("busy_u%0d_c%0d", UN[k], cyc), {319'd0, busy_w[k]}, {319'd0, e_busy});
      if (e_done) begin
        last_st[k] = sb[k][0].st;
        void'(sb[k].pop_front());
        chk($sformatf("result_u%0d_c%0d", UN[k], cyc), st_w[k], last_st[k]);
      end else if (!e_busy) begin
        chk($sformatf("hold_u%0d_c%0d", UN[k], cyc), st_w[k], last_st[k]);
      end
    end
    start = 1'b0;
  endtask

  task automatic scramble();
    mode     = 1'($urandom());
    state_in = rnd320();
    xb_en    = 1'($urandom());
    xb_data  = rnd320()[127:0];
    xe_mode  = 2'($urandom());
    xe_data  = rnd320()[127:0];
  endtask

  // Drive one start pulse and queue the expected result for every idle instance.
  task automatic launch(input logic m, input logic [319:0] s, input logic xben,
                        input logic [127:0] xb, input logic [1:0] xem, input logic [127:0] xe);
    logic [319:0] e;
    int           nr;
    nr       = m ? 8 : 12;
    e        = model(m, s, xben, xb, xem, xe);
    start    = 1'b1;
    mode     = m;
    state_in = s;
    xb_en    = xben;
    xb_data  = xb;
    xe_mode  = xem;
    xe_data  = xe;
    for (int k = 0; k < 3; k++) begin
      if (sb[k].size() == 0) sb[k].push_back('{st: e, due: cyc + nr / UN[k]});
    end
  endtask

  function automatic logic pending();
    return (sb[0].size() > 0) || (sb[1].size() > 0) || (sb[2].size() > 0);
  endfunction

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (pending() && guard < 40) begin
      tick();
      scramble();
      guard++;
    end
    chk("drain_timeout", {319'd0, pending()}, 320'd0);
  endtask

  initial begin
    int guard;
    rst      = 1'b1;
    start    = 1'b0;
    mode     = 1'b0;
    state_in = 320'd0;
    xb_en    = 1'b0;
    xb_data  = 128'd0;
    xe_mode  = 2'b00;
    xe_data  = 128'd0;
    cyc      = 0;
    n_pass   = 0;
    n_fail   = 0;
    n_total  = 0;
    for (int k = 0; k < 3; k++) last_st[k] = 320'd0;

    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_state_u%0d", UN[k]), st_w[k], 320'd0);
      chk($sformatf("rst_busy_u%0d", UN[k]), {319'd0, busy_w[k]}, 320'd0);
      chk($sformatf("rst_done_u%0d", UN[k]), {319'd0, done_w[k]}, 320'd0);
    end
    tick();
    rst = 1'b0;
    tick();

    launch(1'b0, 320'd0, 1'b0, 128'd0, 2'b00, 128'd0);
    wait_idle();

    launch(1'b1, INIT, 1'b1, 128'h00112233445566778899aabbccddeeff, 2'b00, 128'd0);
    wait_idle();

    launch(1'b0, INIT, 1'b0, 128'd0, 2'b01, KEY);
    wait_idle();

    launch(1'b0, rnd320(), 1'b1, rnd320()[127:0], 2'b11, rnd320()[127:0]);
    tick();
    tick();
    start    = 1'b1;
    mode     = 1'b1;
    state_in = rnd320();
    xb_en    = 1'b1;
    xe_mode  = 2'b01;
    xe_data  = rnd320()[127:0];
    wait_idle();

    launch(1'b0, rnd320(), 1'b1, rnd320()[127:0], 2'b10, 128'd0);
    guard = 0;
    while (sb[0].size() > 0 && guard < 40) begin
      tick();
      guard++;
    end
    chk("b2b_first_timeout", {319'd0, sb[0].size() > 0}, 320'd0);
    launch(1'b1, last_st[0], 1'b0, 128'd0, 2'b11, KEY);
    state_in = st_w[0];
    wait_idle();

    launch(1'b0, rnd320(), 1'b1, rnd320()[127:0], 2'b01, rnd320()[127:0]);
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("async_rst_state_u%0d", UN[k]), st_w[k], 320'd0);
      chk($sformatf("async_rst_busy_u%0d", UN[k]), {319'd0, busy_w[k]}, 320'd0);
      chk($sformatf("async_rst_done_u%0d", UN[k]), {319'd0, done_w[k]}, 320'd0);
      sb[k].delete();
      last_st[k] = 320'd0;
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 14; i++) tick();

    launch(1'b1, rnd320(), 1'b0, 128'd0, 2'b10, 128'd0);
    wait_idle();

    launch(1'b0, rnd320(), 1'b1, rnd320()[127:0], 2'b11, rnd320()[127:0]);
    wait_idle();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ascon_perm_engine.md
Name: ascon_perm_engine

Overview:
Self-sequencing Ascon permutation engine for the AEAD128 datapath. It wraps the begin-XOR, round function (Pc -> Ps -> Pl) and end-XOR around an internal round counter. It executes p12 or p8 autonomously after a single start pulse, with UNROLL rounds evaluated per clock. It sits between the AEAD control FSM and the state datapath, and replaces per-round sequencing by the controller with a start/done handshake.

Parameters:
UNROLL, 1, rounds computed per clock; legal values are 1, 2, 4; any other value is an elaboration error.
ROUNDS_A, 12, round count when mode_i=0 (initialisation/finalisation).
ROUNDS_B, 8, round count when mode_i=1 (data processing); both counts must be divisible by UNROLL.

Ports:
clock_i  in  1  system clock, rising edge.
reset_i  in  1  asynchronous, active-high reset.
start_i  in  1  launch permutation; sampled only when busy_o=0.
mode_i  in  1  0 = ROUNDS_A rounds, 1 = ROUNDS_B rounds; sampled with start_i.
state_i  in  320  input state; x0=[319:256] ... x4=[63:0].
xor_b_en_i  in  1  XOR data_xor_b_i into {x0,x1} before the first round.
data_xor_b_i  in  128  begin-XOR data.
xor_e_mode_i  in  2  end-XOR select, applied after the last round only.
data_xor_e_i  in  128  end-XOR data (key).
state_o  out  320  registered state.
busy_o  out  1  permutation in progress.
done_o  out  1  single-cycle pulse; state_o is valid from this cycle.

Behaviour:
- Reset (asynchronous, any time, including mid-run): FSM -> IDLE, state register = 0, round counter = 0, busy_o=0, done_o=0. The operation in flight is discarded.
- FSM states: IDLE, RUN.
  - IDLE & start_i -> RUN. The engine latches mode_i, xor_e_mode_i and data_xor_e_i. It computes s0 = state_i ^ ({data_xor_b_i,192'b0} if xor_b_en_i), applies the first UNROLL rounds to s0, and writes the result to the state register.
  - RUN: each cycle applies UNROLL rounds to the register. On the final group, the end-XOR is applied and the FSM returns to IDLE.
- Round index r (0..11 into the constant table) starts at 12-N, where N is the selected round count. It advances by UNROLL per cycle. Constant for round r = ((15-r)<<4)|r, XORed into the LSB byte of x2. Example sequence: 0xf0, 0xe1, ..., 0x4b.
- Latency: done_o is asserted N/UNROLL cycles after the start cycle. For N=12: 12/6/3 cycles at UNROLL 1/2/4. For N=8: 8/4/2 cycles.
- busy_o=1 from the cycle after start until the cycle done_o pulses, inclusive of that cycle's edge. busy_o is low in the done_o cycle, so a back-to-back start in the done_o cycle is accepted, and state_i may be fed from state_o.
- start_i while busy_o=1 is ignored. It is neither queued nor does it corrupt the latched mode.
- End-XOR (xor_e_mode_i latched):
  - 00: none.
  - 01: {x3,x4} ^= data_xor_e_i.
  - 10: x4[0] ^= 1 (domain separation).
  - 11: both.
- Begin-XOR is applied to state_i only. It never touches an in-flight state.
- state_o holds its value in IDLE until the next accepted start.
- Changes on the input ports during RUN have no effect, except reset_i.
- All round logic is combinational between registers: one 320-bit state register, a 4-bit counter and FSM flops.

Test Plan:
- UNROLL=1, mode 0, state_i=0, no XORs, pulse start -> done_o exactly 12 cycles later; state_o matches the golden p12(0); busy_o is high for cycles 1..11.
- UNROLL=4, mode 1, Ascon-AEAD128 KAT state, xor_b_en_i=1 with data 0x0011..ff -> done_o after 2 cycles; result equals the golden p8 of the XORed state; constant sequence starts at 0xb4.
- Initialisation (IV 0x00001000808c0001, key=nonce=0x000102..0f), mode 0, xor_e_mode_i=01 with the key -> output equals the published AEAD128 post-init state at UNROLL 1, 2 and 4.
- Start pulsed again at cycle 3 of a p12 run with different mode/data -> ignored; output is unchanged vs an undisturbed run; done_o pulses once.
- Back-to-back: start in the done_o cycle with state_i=state_o and mode 1 -> second done_o arrives N/UNROLL cycles later; no idle bubble.
- reset_i asserted asynchronously mid-RUN (between clock edges) -> state_o=0 and busy_o=0 immediately; no done_o; the next start runs correctly.
